rect_counter_dec: RTL and testbench
===================================

Name: rect_counter_dec

Overview:
- Round-constant sequencer for the decryption key schedule: runs the 5-bit RECTANGLE round-constant LFSR backwards, from the last-round constant down to the first.
- Pairs with the forward round counter used by the encryption key schedule.
- Sits beside the decryption key-schedule register and is stepped once per round by the decrypt datapath through a start/advance/done handshake.

Parameters:
- ROUNDS, 25, number of rounds; constants issued per run; legal range 1..32.
- RC_LAST, 5'h1D, constant loaded at start (forward RC of the final round).
- RC_FIRST, 5'h01, constant expected at round 0; used only by the optional check.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  one-cycle request to begin a run
- advance  in  1  datapath consumed current rc; step to the previous round
- abort  in  1  synchronous cancel of a run
- rc  out  5  current round constant {rc4..rc0}
- round  out  5  current round index, counts ROUNDS-1 down to 0
- busy  out  1  run in progress (state RUN)
- last  out  1  busy && round==0
- done  out  1  one-cycle pulse after the final advance
- rc_err  out  1  sticky check flag (optional feature)

Behaviour:
- Inverse step, n = current rc: prev = {n0^n3, n4, n3, n2, n1}. This is the exact inverse of the forward step {n3, n2, n1, n0, n4^n2}.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from registered state only.
- Reset (reset==0, asynchronous, no clock needed): state=IDLE, rc=RC_LAST, round=ROUNDS-1, busy=0, done=0, rc_err=0.
- IDLE:
  - start=1 -> RUN next edge; rc<=RC_LAST; round<=ROUNDS-1.
  - advance is ignored in IDLE.
- RUN:
  - advance=1 with round!=0 -> rc<=prev(rc); round<=round-1.
  - advance=1 with round==0 -> DONE; rc and round hold.
  - advance=0 -> everything holds (stall, unbounded).
  - start is ignored in RUN.
- DONE:
  - lasts exactly one cycle; done=1, busy=0; then IDLE.
  - start=1 during DONE -> RUN with reload (back-to-back runs); done still pulses.
- abort=1 in any state -> IDLE next edge; rc<=RC_LAST; round<=ROUNDS-1; done is not asserted.
- Simultaneous events: abort beats start and advance; reset beats everything.
- Latency: rc/round are valid the cycle after start is sampled. Each advance updates rc on the next edge. done follows the final advance by 1 cycle.
- A minimum run (no stalls) is ROUNDS+1 cycles from start to done.
- round is 5-bit unsigned and never wraps: round==0 plus advance exits to DONE instead of decrementing.

Optional Feature:
- Macro: RECT_RC_CHECK_EN.
- Defined:
  - On the final advance (RUN, round==0, advance=1), compare rc with RC_FIRST.
  - On mismatch, rc_err<=1; it stays set until reset or the next accepted start.
- Undefined: rc_err tied to 0; no compare logic.

Decomposition:
- Package rect_pkg:
  - RC_W=5, ROUNDS_DEF=25, RC_FIRST_DEF=5'h01, RC_LAST_DEF=5'h1D.
  - State enum {IDLE, RUN, DONE}.
  - Function rc_step_inv.
- Sub-module rect_rc_lfsr_inv: purely combinational one-step inverse (5 in, 5 out). Instanced once here and reusable by the bench reference model.

Test Plan:
- Reset, start, advance held high:
  - rc sequence 1D,0E,17,1B,0D,06,03,11,18,1C,1E,1F,0F,07,13,19,0C,16,0B,05,12,09,04,02,01 with round 24..0.
  - last=1 only with rc=01.
  - done=1 exactly one cycle after the 25th advance; busy=0 in the same cycle.
- Advance gapped (1 high, 3 low, repeated): rc and round hold during low cycles; same 25-value sequence; done after the 25th advance.
- Abort at round 12 (rc=0F) together with advance=1: next cycle IDLE, rc=1D, round=24, busy=0; done never asserts.
- reset driven low mid-run (round 7), between clock edges: rc=1D, round=24, busy=0 immediately. start while busy is ignored (rc sequence undisturbed). start in the DONE cycle restarts: busy=1 next cycle with rc=1D.
- RECT_RC_CHECK_EN defined:
  - RC_LAST=1D: rc_err stays 0.
  - RC_LAST overridden to 1A: final rc=02 -> rc_err=1, held through IDLE, cleared by the next start.
  - Macro undefined: rc_err=0 throughout.

Source files
------------

// File: rtl/rect_pkg.sv
// Shared types and helpers for the RECTANGLE decryption round-constant sequencer.
package rect_pkg;

  localparam int unsigned     RC_W         = 5;
  localparam int unsigned     ROUNDS_DEF   = 25;
  localparam logic [RC_W-1:0] RC_FIRST_DEF = 5'h01;
  localparam logic [RC_W-1:0] RC_LAST_DEF  = 5'h1D;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Undoes the forward step {n3, n2, n1, n0, n4^n2}.
  function automatic logic [RC_W-1:0] rc_step_inv(input logic [RC_W-1:0] n);
    return {n[0] ^ n[3], n[4], n[3], n[2], n[1]};
  endfunction

endpackage

// File: rtl/rect_rc_lfsr_inv.sv
// One combinational backwards step of the 5-bit RECTANGLE round-constant LFSR.
module rect_rc_lfsr_inv
  import rect_pkg::*;
(
  input  logic [RC_W-1:0] rc_i,
  output logic [RC_W-1:0] rc_o
);

  assign rc_o = rc_step_inv(rc_i);

endmodule

// File: rtl/rect_counter_dec.sv
// Decryption round-constant sequencer: walks the RC LFSR from RC_LAST back to round 0.
// Optional final-constant self-check enabled by defining RECT_RC_CHECK_EN.
module rect_counter_dec
  import rect_pkg::*;
#(
  parameter int unsigned     ROUNDS   = ROUNDS_DEF,
  parameter logic [RC_W-1:0] RC_LAST  = RC_LAST_DEF,
  parameter logic [RC_W-1:0] RC_FIRST = RC_FIRST_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            advance,
  input  logic            abort,
  output logic [RC_W-1:0] rc,
  output logic [RC_W-1:0] round,
  output logic            busy,
  output logic            last,
  output logic            done,
  output logic            rc_err
);

  localparam logic [RC_W-1:0] ROUND_INIT = RC_W'(ROUNDS - 1);

  // An all-zero constant locks the LFSR, so it can never be a valid endpoint.
  if (ROUNDS < 1 || ROUNDS > 32 || RC_LAST == '0 || RC_FIRST == '0) begin : g_cfg_bad
    $error("rect_counter_dec: ROUNDS out of 1..32 or all-zero round constant");
  end

  state_e          state_q, state_d;
  logic [RC_W-1:0] rc_q, rc_d;
  logic [RC_W-1:0] round_q, round_d;
  logic [RC_W-1:0] rc_prev;

  rect_rc_lfsr_inv u_lfsr_inv (
    .rc_i (rc_q),
    .rc_o (rc_prev)
  );

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    round_d = round_q;
    if (abort) begin
      state_d = IDLE;
      rc_d    = RC_LAST;
      round_d = ROUND_INIT;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            rc_d    = RC_LAST;
            round_d = ROUND_INIT;
          end
        end
        RUN: begin
          if (advance) begin
            if (round_q != '0) begin
              rc_d    = rc_prev;
              round_d = round_q - 5'd1;
            end else begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (start) begin
            state_d = RUN;
            rc_d    = RC_LAST;
            round_d = ROUND_INIT;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rc_q    <= RC_LAST;
      round_q <= ROUND_INIT;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      round_q <= round_d;
    end
  end

  assign rc    = rc_q;
  assign round = round_q;
  assign busy  = (state_q == RUN);
  assign last  = (state_q == RUN) && (round_q == '0);
  assign done  = (state_q == DONE);

`ifdef RECT_RC_CHECK_EN
  logic rc_err_q, rc_err_d;
  logic accept_start, final_adv;

  assign accept_start = !abort && start && (state_q == IDLE || state_q == DONE);
  assign final_adv    = !abort && advance && (state_q == RUN) && (round_q == '0);

  always_comb begin
    rc_err_d = rc_err_q;
    if (accept_start) begin
      rc_err_d = 1'b0;
    end else if (final_adv && (rc_q != RC_FIRST)) begin
      rc_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rc_err_q <= 1'b0;
    end else begin
      rc_err_q <= rc_err_d;
    end
  end

  assign rc_err = rc_err_q;
`else
  assign rc_err = 1'b0;
`endif

endmodule

// File: tb/tb_rect_counter_dec.sv
// Scoreboard bench for rect_counter_dec: default instance plus an RC_LAST=1A instance.
module tb_rect_counter_dec;

  localparam int R = 25;

  logic       clk, reset, start, advance, abort;
  logic [4:0] rc_a, round_a, rc_b, round_b;
  logic       busy_a, last_a, done_a, err_a;
  logic       busy_b, last_b, done_b, err_b;

  rect_counter_dec u_dut_a (
    .clk(clk), .reset(reset), .start(start), .advance(advance), .abort(abort),
    .rc(rc_a), .round(round_a), .busy(busy_a), .last(last_a), .done(done_a), .rc_err(err_a)
  );

  rect_counter_dec #(.RC_LAST(5'h1A)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .advance(advance), .abort(abort),
    .rc(rc_b), .round(round_b), .busy(busy_b), .last(last_b), .done(done_b), .rc_err(err_b)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0] rc_a;
    logic [4:0] rc_b;
    logic [4:0] rnd;
    logic       busy;
    logic       last;
    logic       done;
    logic       err_a;
    logic       err_b;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Expected constants by round index; the default table is the published sequence.
  logic [4:0] seq_a[R] = '{5'h1D, 5'h0E, 5'h17, 5'h1B, 5'h0D, 5'h06, 5'h03, 5'h11, 5'h18,
                           5'h1C, 5'h1E, 5'h1F, 5'h0F, 5'h07, 5'h13, 5'h19, 5'h0C, 5'h16,
                           5'h0B, 5'h05, 5'h12, 5'h09, 5'h04, 5'h02, 5'h01};
  logic [4:0] tbl_a[R];
  logic [4:0] tbl_b[R];

  function automatic int inv_step(int n);
    return (((n & 1) ^ ((n >> 3) & 1)) << 4) | (n >> 1);
  endfunction

  initial begin
    int v;
    for (int i = 0; i < R; i++) tbl_a[R-1-i] = seq_a[i];
    v = 'h1A;
    for (int r = R - 1; r >= 0; r--) begin
      tbl_b[r] = 5'(v);
      v = inv_step(v);
    end
  end

  // Reference model: mode 0 idle, 1 running, 2 done pulse; rnd is the round index.
  int   mode;
  int   rnd;
  logic e_a, e_b;
  bit   armed = 0;

  function automatic exp_t snap();
    exp_t e;
    e.rc_a  = tbl_a[rnd];
    e.rc_b  = tbl_b[rnd];
    e.rnd   = 5'(rnd);
    e.busy  = (mode == 1);
    e.last  = (mode == 1) && (rnd == 0);
    e.done  = (mode == 2);
    e.err_a = e_a;
    e.err_b = e_b;
    return e;
  endfunction

  task automatic model_step(input logic st, input logic adv, input logic ab);
    if (ab) begin
      mode = 0;
      rnd  = R - 1;
    end else if (mode == 1) begin
      if (adv) begin
        if (rnd != 0) rnd = rnd - 1;
        else begin
          mode = 2;
`ifdef RECT_RC_CHECK_EN
          if (tbl_a[0] != 5'h01) e_a = 1'b1;
          if (tbl_b[0] != 5'h01) e_b = 1'b1;
`endif
        end
      end
    end else if (st) begin
      mode = 1;
      rnd  = R - 1;
      e_a  = 1'b0;
      e_b  = 1'b0;
    end else begin
      mode = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      armed = 1;
      mode  = 0;
      rnd   = R - 1;
      e_a   = 1'b0;
      e_b   = 1'b0;
      q.delete();
      q.push_back(snap());
    end else if (armed) begin
      model_step(start, advance, abort);
      q.push_back(snap());
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk or negedge reset);
    #1;
    if (armed) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_empty: got 0 entries expected 1 at t=%0t", $time);
      end else begin
        e = q.pop_front();
        chk("rc_a",    {3'b0, rc_a},    {3'b0, e.rc_a});
        chk("round_a", {3'b0, round_a}, {3'b0, e.rnd});
        chk("busy_a",  {7'b0, busy_a},  {7'b0, e.busy});
        chk("last_a",  {7'b0, last_a},  {7'b0, e.last});
        chk("done_a",  {7'b0, done_a},  {7'b0, e.done});
        chk("err_a",   {7'b0, err_a},   {7'b0, e.err_a});
        chk("rc_b",    {3'b0, rc_b},    {3'b0, e.rc_b});
        chk("round_b", {3'b0, round_b}, {3'b0, e.rnd});
        chk("busy_b",  {7'b0, busy_b},  {7'b0, e.busy});
        chk("last_b",  {7'b0, last_b},  {7'b0, e.last});
        chk("done_b",  {7'b0, done_b},  {7'b0, e.done});
        chk("err_b",   {7'b0, err_b},   {7'b0, e.err_b});
      end
    end
  end

  task automatic drive(input logic st, input logic adv, input logic ab);
    @(negedge clk);
    start   = st;
    advance = adv;
    abort   = ab;
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    advance = 1'b0;
    abort   = 1'b0;
    #7 reset = 1'b0;
    repeat (2) drive(0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    // Full run with advance held high (start cycle also carries advance).
    drive(1, 1, 0);
    repeat (R) drive(0, 1, 0);
    repeat (3) drive(0, 0, 0);

    // Gapped advance: one high, three low.
    drive(1, 0, 0);
    repeat (R) begin
      drive(0, 1, 0);
      repeat (3) drive(0, 0, 0);
    end
    repeat (2) drive(0, 0, 0);

    // Abort at round 12 together with advance.
    drive(1, 0, 0);
    repeat (12) drive(0, 1, 0);
    drive(0, 1, 1);
    repeat (3) drive(0, 0, 0);

    // start while busy is ignored; start in the done cycle restarts.
    drive(1, 0, 0);
    for (int i = 0; i < R; i++) drive(1'(i % 2), 1, 0);
    drive(1, 0, 0);
    repeat (5) drive(0, 1, 0);
    drive(0, 0, 1);
    drive(0, 0, 0);

    // Asynchronous reset mid-run at round 7, between clock edges.
    drive(1, 0, 0);
    repeat (17) drive(0, 1, 0);
    #2 reset = 1'b0;
    repeat (2) drive(0, 1, 0);
    @(negedge clk);
    reset   = 1'b1;
    advance = 1'b0;

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 49) == 0));
    end
    repeat (3) drive(0, 0, 0);
    @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
